// File: rtl/opb_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : opb_master_pkg
// Brief    : Shared types and constants for the single-beat OPB master.
// Revision : 1.0
// ============================================================================
package opb_master_pkg;

    localparam int OPB_AWIDTH  = 32;
    localparam int OPB_DWIDTH  = 32;
    localparam int OPB_BEWIDTH = OPB_DWIDTH / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        XFER    = 3'd2,
        BACKOFF = 3'd3,
        RESP    = 3'd4
    } state_e;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_ERR     = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_RETRY   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/opb_master_timeout.sv
`default_nettype none
// ============================================================================
// Module   : opb_master_timeout
// Brief    : Select-cycle counter with clear, hold and terminal flag.
// Revision : 1.0
// ============================================================================
module opb_master_timeout
    import opb_master_pkg::*;
#(
    parameter int C_TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic hold_i,
    output logic expired_o
);

    localparam int              CW   = 8;
    localparam logic [CW-1:0]   LAST = CW'(C_TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (!hold_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires during the C_TIMEOUT-th counted select cycle.
    assign expired_o = !clr_i && !hold_i && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/opb_master_single.sv
`default_nettype none
// ============================================================================
// Module   : opb_master_single
// Brief    : Single-beat OPB master with retry, error and timeout handling.
// Revision : 1.0
// ============================================================================
module opb_master_single
    import opb_master_pkg::*;
#(
    parameter int    C_OPB_AWIDTH = 32,
    parameter int    C_OPB_DWIDTH = 32,
    parameter int    C_TIMEOUT    = 16,
    parameter int    C_MAX_RETRY  = 4,
    parameter string C_FAMILY     = "virtex6"
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    output logic                      M_request,
    input  logic                      OPB_MGrant,
    output logic                      M_select,
    output logic [0:C_OPB_AWIDTH-1]   M_ABus,
    output logic [0:C_OPB_DWIDTH/8-1] M_BE,
    output logic [0:C_OPB_DWIDTH-1]   M_DBus,
    output logic                      M_RNW,
    output logic                      M_seqAddr,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_xferAck,
    input  logic                      OPB_errAck,
    input  logic                      OPB_retry,
    input  logic                      OPB_toutSup,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_rnw,
    input  logic [0:C_OPB_AWIDTH-1]   cmd_addr,
    input  logic [0:C_OPB_DWIDTH/8-1] cmd_be,
    input  logic [0:C_OPB_DWIDTH-1]   cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [0:C_OPB_DWIDTH-1]   rsp_rdata,
    output logic [1:0]                rsp_status
);

    localparam int AW = C_OPB_AWIDTH;
    localparam int DW = C_OPB_DWIDTH;
    localparam int BW = C_OPB_DWIDTH / 8;

    if ((C_TIMEOUT < 2) || (C_TIMEOUT > 255) || (C_MAX_RETRY < 0) || (C_MAX_RETRY > 15)
        || (AW != OPB_AWIDTH) || (DW != OPB_DWIDTH)) begin : g_param_check
        $error("opb_master_single (%s): parameter out of range", C_FAMILY);
    end

    state_e         state_q, state_d;
    logic [0:AW-1]  addr_q, addr_d;
    logic [0:BW-1]  be_q, be_d;
    logic [0:DW-1]  wdata_q, wdata_d;
    logic           rnw_q, rnw_d;
    logic [3:0]     retry_q, retry_d;
    logic [0:DW-1]  rdata_q, rdata_d;
    logic [1:0]     status_q, status_d;
    logic           tout_clr;
    logic           tout_expired;

    assign tout_clr = (state_q != XFER);

    opb_master_timeout #(
        .C_TIMEOUT (C_TIMEOUT)
    ) u_timeout (
        .clk_i     (OPB_Clk),
        .rst_ni    (OPB_Rst_n),
        .clr_i     (tout_clr),
        .hold_i    (OPB_toutSup),
        .expired_o (tout_expired)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rnw_d    = rnw_q;
        retry_d  = retry_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d   = cmd_addr;
                    be_d     = cmd_be;
                    wdata_d  = cmd_wdata;
                    rnw_d    = cmd_rnw;
                    retry_d  = '0;
                    rdata_d  = '0;
                    status_d = ST_OK;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (OPB_MGrant) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                // Acknowledge priority: errAck, xferAck, retry, timeout.
                if (OPB_errAck) begin
                    status_d = ST_ERR;
                    state_d  = RESP;
                end else if (OPB_xferAck) begin
                    if (rnw_q) begin
                        rdata_d = OPB_DBus;
                    end
                    status_d = ST_OK;
                    state_d  = RESP;
                end else if (OPB_retry) begin
                    if (retry_q == 4'(C_MAX_RETRY)) begin
                        status_d = ST_RETRY;
                        state_d  = RESP;
                    end else begin
                        retry_d = retry_q + 4'd1;
                        state_d = BACKOFF;
                    end
                end else if (tout_expired) begin
                    status_d = ST_TIMEOUT;
                    state_d  = RESP;
                end
            end
            BACKOFF: begin
                state_d = REQ;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rnw_q    <= 1'b0;
            retry_q  <= '0;
            rdata_q  <= '0;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rnw_q    <= rnw_d;
            retry_q  <= retry_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
        end
    end

    // Outputs decode from state only, so reset releases the bus without a clock.
    assign M_request  = (state_q == REQ);
    assign M_select   = (state_q == XFER);
    assign M_ABus     = M_select ? addr_q  : '0;
    assign M_BE       = M_select ? be_q    : '0;
    assign M_DBus     = (M_select && !rnw_q) ? wdata_q : '0;
    assign M_RNW      = M_select ? rnw_q   : 1'b0;
    assign M_seqAddr  = 1'b0;
    assign cmd_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_rdata  = rsp_valid ? rdata_q  : '0;
    assign rsp_status = rsp_valid ? status_q : ST_OK;

endmodule
`default_nettype wire

// File: tb/tb_opb_master_single.sv
`default_nettype none
// ============================================================================
// Module   : tb_opb_master_single
// Brief    : Directed self-checking bench for opb_master_single.
// Revision : 1.0
// ============================================================================
module tb_opb_master_single;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        M_request, OPB_MGrant = 1'b0, M_select;
    logic [0:31] M_ABus, M_DBus, OPB_DBus = '0, cmd_addr = '0, cmd_wdata = '0, rsp_rdata;
    logic [0:3]  M_BE, cmd_be = '0;
    logic        M_RNW, M_seqAddr;
    logic        OPB_xferAck = 1'b0, OPB_errAck = 1'b0, OPB_retry = 1'b0, OPB_toutSup = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_rnw = 1'b0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [1:0]  rsp_status;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    opb_master_single #(
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_TIMEOUT    (16),
        .C_MAX_RETRY  (4),
        .C_FAMILY     ("virtex6")
    ) dut (
        .OPB_Clk     (clk),
        .OPB_Rst_n   (rst_n),
        .M_request   (M_request),
        .OPB_MGrant  (OPB_MGrant),
        .M_select    (M_select),
        .M_ABus      (M_ABus),
        .M_BE        (M_BE),
        .M_DBus      (M_DBus),
        .M_RNW       (M_RNW),
        .M_seqAddr   (M_seqAddr),
        .OPB_DBus    (OPB_DBus),
        .OPB_xferAck (OPB_xferAck),
        .OPB_errAck  (OPB_errAck),
        .OPB_retry   (OPB_retry),
        .OPB_toutSup (OPB_toutSup),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rnw     (cmd_rnw),
        .cmd_addr    (cmd_addr),
        .cmd_be      (cmd_be),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_status  (rsp_status)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic issue(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd);
        cmd_rnw   = rnw;
        cmd_addr  = addr;
        cmd_be    = be;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("req_after_accept", 32'(M_request), 32'd1);
        chk("ready_low_req", 32'(cmd_ready), 32'd0);
    endtask

    task automatic grant_to_xfer(input string tag);
        OPB_MGrant = 1'b1;
        tick();
        OPB_MGrant = 1'b0;
        chk(tag, 32'(M_select), 32'd1);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_consumed", 32'(rsp_valid), 32'd0);
        chk("ready_back", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int cnt;
        int gaps;

        // Reset state
        tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_request", 32'(M_request), 32'd0);
        chk("rst_select", 32'(M_select), 32'd0);
        chk("rst_abus", M_ABus, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_seqaddr", 32'(M_seqAddr), 32'd0);
        rst_n = 1'b1;
        tick();

        // Write, grant after 2 request cycles, ack on first select cycle
        issue(1'b0, 32'h01088200, 4'hF, 32'hDEADBEEF);
        chk("wr_abus_idle", M_ABus, 32'h0);
        chk("wr_dbus_idle", M_DBus, 32'h0);
        tick();
        chk("wr_req_hold", 32'(M_request), 32'd1);
        chk("wr_sel_low", 32'(M_select), 32'd0);
        grant_to_xfer("wr_select");
        chk("wr_request_off", 32'(M_request), 32'd0);
        chk("wr_abus", M_ABus, 32'h01088200);
        chk("wr_be", 32'(M_BE), 32'hF);
        chk("wr_dbus", M_DBus, 32'hDEADBEEF);
        chk("wr_rnw", 32'(M_RNW), 32'd0);
        OPB_xferAck = 1'b1;
        tick();
        OPB_xferAck = 1'b0;
        chk("wr_sel_drop", 32'(M_select), 32'd0);
        chk("wr_abus_after", M_ABus, 32'h0);
        chk("wr_be_after", 32'(M_BE), 32'h0);
        chk("wr_dbus_after", M_DBus, 32'h0);
        chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_status", 32'(rsp_status), 32'd0);
        chk("wr_rdata", rsp_rdata, 32'h0);
        consume();

        // Read, ack on third select cycle, response held while rsp_ready low
        issue(1'b1, 32'h01088200, 4'hF, 32'h0);
        grant_to_xfer("rd_select");
        chk("rd_rnw", 32'(M_RNW), 32'd1);
        chk("rd_dbus_zero", M_DBus, 32'h0);
        tick();
        tick();
        chk("rd_sel_3rd", 32'(M_select), 32'd1);
        OPB_DBus    = 32'h12345678;
        OPB_xferAck = 1'b1;
        tick();
        OPB_xferAck = 1'b0;
        OPB_DBus    = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk("rd_hold_valid", 32'(rsp_valid), 32'd1);
            chk("rd_hold_rdata", rsp_rdata, 32'h12345678);
            chk("rd_hold_status", 32'(rsp_status), 32'd0);
            tick();
        end
        consume();

        // Four retries then success
        issue(1'b1, 32'h00000040, 4'h3, 32'h0);
        gaps = 0;
        for (int i = 0; i < 4; i++) begin
            grant_to_xfer("rt_select");
            OPB_retry = 1'b1;
            tick();
            OPB_retry = 1'b0;
            if (!M_select && !M_request) gaps++;
            tick();
            chk("rt_rereq", 32'(M_request), 32'd1);
        end
        chk("rt_gaps", 32'(gaps), 32'd4);
        grant_to_xfer("rt_final_sel");
        OPB_DBus    = 32'hA5A5A5A5;
        OPB_xferAck = 1'b1;
        tick();
        OPB_xferAck = 1'b0;
        OPB_DBus    = 32'h0;
        chk("rt_status", 32'(rsp_status), 32'd0);
        chk("rt_rdata", rsp_rdata, 32'hA5A5A5A5);
        consume();

        // Five retries exhaust the budget
        issue(1'b1, 32'h00000044, 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) begin
            grant_to_xfer("rx_select");
            OPB_retry = 1'b1;
            tick();
            OPB_retry = 1'b0;
            chk("rx_backoff", 32'(rsp_valid), 32'd0);
            tick();
        end
        grant_to_xfer("rx_5th_sel");
        OPB_retry = 1'b1;
        tick();
        OPB_retry = 1'b0;
        chk("rx_valid", 32'(rsp_valid), 32'd1);
        chk("rx_status", 32'(rsp_status), 32'd3);
        chk("rx_rdata", rsp_rdata, 32'h0);
        consume();

        // Timeout with toutSup low: 16 select cycles
        issue(1'b1, 32'h00000100, 4'hF, 32'h0);
        grant_to_xfer("to_select");
        cnt = 0;
        while (M_select && cnt < 100) begin
            cnt++;
            tick();
        end
        chk("to_cycles", 32'(cnt), 32'd16);
        chk("to_status", 32'(rsp_status), 32'd2);
        chk("to_valid", 32'(rsp_valid), 32'd1);
        consume();

        // Timeout suppressed for the first 10 select cycles: 26 select cycles
        issue(1'b1, 32'h00000104, 4'hF, 32'h0);
        grant_to_xfer("ts_select");
        cnt = 0;
        while (M_select && cnt < 100) begin
            cnt++;
            OPB_toutSup = (cnt <= 10);
            tick();
        end
        OPB_toutSup = 1'b0;
        chk("ts_cycles", 32'(cnt), 32'd26);
        chk("ts_status", 32'(rsp_status), 32'd2);
        consume();

        // errAck and xferAck together: error wins
        issue(1'b1, 32'h00000200, 4'hF, 32'h0);
        grant_to_xfer("ea_select");
        OPB_DBus    = 32'hCAFEF00D;
        OPB_errAck  = 1'b1;
        OPB_xferAck = 1'b1;
        tick();
        OPB_errAck  = 1'b0;
        OPB_xferAck = 1'b0;
        OPB_DBus    = 32'h0;
        chk("ea_status", 32'(rsp_status), 32'd1);
        chk("ea_rdata", rsp_rdata, 32'h0);
        consume();

        // Reset in the middle of XFER
        issue(1'b0, 32'h00000300, 4'hF, 32'h11223344);
        grant_to_xfer("rs_select");
        #2 rst_n = 1'b0;
        #1;
        chk("rs_sel_async", 32'(M_select), 32'd0);
        chk("rs_abus_async", M_ABus, 32'h0);
        chk("rs_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        tick();
        chk("rs_ready", 32'(cmd_ready), 32'd1);
        chk("rs_no_rsp", 32'(rsp_valid), 32'd0);
        chk("rs_no_req", 32'(M_request), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
